// File: rtl/ir_field_decoder.sv
// Instruction register with field split for the multicycle MIPS datapath.
// Latency: MEM_LATENCY+1 edges from ir_write to instr_valid; all fields are registered.
// Backpressure: none; ir_write during WAIT is dropped and busy flags the pending load.
module ir_field_decoder #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ir_write,
    input  logic [31:0] mem_data_in,
    output logic        busy,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] immediate,
    output logic [25:0] index26,
    output logic [31:0] imm_sext,
    output logic [31:0] imm_zext,
    output logic [1:0]  fmt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2
    } state_t;

    localparam bit          ZERO_LAT = (MEM_LATENCY == 0);
    localparam int          LOAD_INT = (MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0;
    localparam logic [2:0]  LOAD_CNT = LOAD_INT[2:0];

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] instr_q, instr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            instr_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        case (state_q)
            IDLE, VALID: begin
                // Old word stays on the outputs until the new one lands.
                if (ir_write) begin
                    if (ZERO_LAT) begin
                        instr_d = mem_data_in;
                        state_d = VALID;
                    end else begin
                        cnt_d   = LOAD_CNT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    instr_d = mem_data_in;
                    state_d = VALID;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q == WAIT);
    assign instr_valid = (state_q == VALID);

    assign instr_out = instr_q;
    assign opcode    = instr_q[31:26];
    assign rs        = instr_q[25:21];
    assign rt        = instr_q[20:16];
    assign rd        = instr_q[15:11];
    assign shamt     = instr_q[10:6];
    assign funct     = instr_q[5:0];
    assign immediate = instr_q[15:0];
    assign index26   = instr_q[25:0];
    assign imm_sext  = {{16{instr_q[15]}}, instr_q[15:0]};
    assign imm_zext  = {16'h0000, instr_q[15:0]};

    always_comb begin
        fmt = 2'b01;
        if (instr_q[31:26] == 6'd0)
            fmt = 2'b00;
        else if (instr_q[31:26] == 6'd2 || instr_q[31:26] == 6'd3)
            fmt = 2'b10;
    end

endmodule

// File: tb/tb_ir_field_decoder.sv
// Directed bench for ir_field_decoder at memory latencies 1, 3 and 0.
module tb_ir_field_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: MEM_LATENCY=1
    logic        rst_a, wr_a;
    logic [31:0] mem_a;
    logic        busy_a, vld_a;
    logic [31:0] io_a, sx_a, zx_a;
    logic [5:0]  op_a, fn_a;
    logic [4:0]  rs_a, rt_a, rd_a, sh_a;
    logic [15:0] im_a;
    logic [25:0] ix_a;
    logic [1:0]  fmt_a;

    // Instance B: MEM_LATENCY=3
    logic        rst_b, wr_b;
    logic [31:0] mem_b;
    logic        busy_b, vld_b;
    logic [31:0] io_b, sx_b, zx_b;
    logic [5:0]  op_b, fn_b;
    logic [4:0]  rs_b, rt_b, rd_b, sh_b;
    logic [15:0] im_b;
    logic [25:0] ix_b;
    logic [1:0]  fmt_b;

    // Instance C: MEM_LATENCY=0
    logic        rst_c, wr_c;
    logic [31:0] mem_c;
    logic        busy_c, vld_c;
    logic [31:0] io_c, sx_c, zx_c;
    logic [5:0]  op_c, fn_c;
    logic [4:0]  rs_c, rt_c, rd_c, sh_c;
    logic [15:0] im_c;
    logic [25:0] ix_c;
    logic [1:0]  fmt_c;

    ir_field_decoder #(.MEM_LATENCY(1)) u_a (
        .clk(clk), .reset(rst_a), .ir_write(wr_a), .mem_data_in(mem_a),
        .busy(busy_a), .instr_valid(vld_a), .instr_out(io_a), .opcode(op_a),
        .rs(rs_a), .rt(rt_a), .rd(rd_a), .shamt(sh_a), .funct(fn_a),
        .immediate(im_a), .index26(ix_a), .imm_sext(sx_a), .imm_zext(zx_a), .fmt(fmt_a)
    );

    ir_field_decoder #(.MEM_LATENCY(3)) u_b (
        .clk(clk), .reset(rst_b), .ir_write(wr_b), .mem_data_in(mem_b),
        .busy(busy_b), .instr_valid(vld_b), .instr_out(io_b), .opcode(op_b),
        .rs(rs_b), .rt(rt_b), .rd(rd_b), .shamt(sh_b), .funct(fn_b),
        .immediate(im_b), .index26(ix_b), .imm_sext(sx_b), .imm_zext(zx_b), .fmt(fmt_b)
    );

    ir_field_decoder #(.MEM_LATENCY(0)) u_c (
        .clk(clk), .reset(rst_c), .ir_write(wr_c), .mem_data_in(mem_c),
        .busy(busy_c), .instr_valid(vld_c), .instr_out(io_c), .opcode(op_c),
        .rs(rs_c), .rt(rt_c), .rd(rd_c), .shamt(sh_c), .funct(fn_c),
        .immediate(im_c), .index26(ix_c), .imm_sext(sx_c), .imm_zext(zx_c), .fmt(fmt_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Latency-1 load: pulse on one edge, data captured on the next.
    task automatic load_a(input logic [31:0] w);
        mem_a = w;
        wr_a  = 1'b1;
        tick();
        wr_a  = 1'b0;
        tick();
    endtask

    initial begin
        rst_a = 1'b1; wr_a = 1'b0; mem_a = 32'hDEADBEEF;
        rst_b = 1'b1; wr_b = 1'b0; mem_b = 32'hDEADBEEF;
        rst_c = 1'b1; wr_c = 1'b0; mem_c = 32'hDEADBEEF;
        tick();
        tick();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // Reset state
        chk("rst_busy",  {31'd0, busy_a}, 32'd0);
        chk("rst_valid", {31'd0, vld_a},  32'd0);
        chk("rst_instr", io_a, 32'd0);
        chk("rst_sext",  sx_a, 32'd0);
        chk("rst_zext",  zx_a, 32'd0);
        chk("rst_fields", {op_a, rs_a, rt_a, rd_a, sh_a, fn_a}, 32'd0);
        chk("rst_misc",  {im_a, fmt_a, 14'd0}, 32'd0);
        chk("rst_idx",   {6'd0, ix_a}, 32'd0);
        chk("rst_b_busy", {31'd0, busy_b}, 32'd0);
        chk("rst_c_valid", {31'd0, vld_c}, 32'd0);

        // R-type add $9,$10,$11 at latency 1
        mem_a = 32'h014B4820;
        wr_a  = 1'b1;
        tick();
        wr_a  = 1'b0;
        chk("r_wait_busy",  {31'd0, busy_a}, 32'd1);
        chk("r_wait_valid", {31'd0, vld_a},  32'd0);
        tick();
        chk("r_valid", {31'd0, vld_a},  32'd1);
        chk("r_busy",  {31'd0, busy_a}, 32'd0);
        chk("r_op",    op_a, 32'd0);
        chk("r_rs",    rs_a, 32'd10);
        chk("r_rt",    rt_a, 32'd11);
        chk("r_rd",    rd_a, 32'd9);
        chk("r_shamt", sh_a, 32'd0);
        chk("r_funct", fn_a, 32'h20);
        chk("r_fmt",   fmt_a, 32'd0);
        chk("r_imm",   im_a, 32'h4820);

        // lw: during the wait the old word must remain visible
        mem_a = 32'h8D0A0004;
        wr_a  = 1'b1;
        tick();
        wr_a  = 1'b0;
        chk("lw_hold_instr", io_a, 32'h014B4820);
        chk("lw_hold_valid", {31'd0, vld_a}, 32'd0);
        tick();
        chk("lw_op",   op_a, 32'h23);
        chk("lw_rs",   rs_a, 32'd8);
        chk("lw_rt",   rt_a, 32'd10);
        chk("lw_imm",  im_a, 32'h0004);
        chk("lw_sext", sx_a, 32'h00000004);
        chk("lw_fmt",  fmt_a, 32'd1);

        // addi with negative immediate
        load_a(32'h2108FFFC);
        chk("neg_op",   op_a, 32'h08);
        chk("neg_sext", sx_a, 32'hFFFFFFFC);
        chk("neg_zext", zx_a, 32'h0000FFFC);
        chk("neg_fmt",  fmt_a, 32'd1);

        // j and jal
        load_a(32'h08100003);
        chk("j_op",    op_a, 32'd2);
        chk("j_index", ix_a, 32'h0100003);
        chk("j_fmt",   fmt_a, 32'd2);
        load_a(32'h0C100003);
        chk("jal_op",  op_a, 32'd3);
        chk("jal_fmt", fmt_a, 32'd2);

        // Latency 3: second ir_write during WAIT is ignored
        mem_b = 32'h8D0A0004;
        wr_b  = 1'b1;
        tick();
        chk("l3_busy1", {31'd0, busy_b}, 32'd1);
        tick();
        wr_b  = 1'b0;
        chk("l3_busy2", {31'd0, busy_b}, 32'd1);
        tick();
        chk("l3_busy3",  {31'd0, busy_b}, 32'd1);
        chk("l3_valid3", {31'd0, vld_b},  32'd0);
        tick();
        chk("l3_valid4", {31'd0, vld_b},  32'd1);
        chk("l3_busy4",  {31'd0, busy_b}, 32'd0);
        chk("l3_instr",  io_b, 32'h8D0A0004);
        mem_b = 32'h2108FFFC;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("l3_nosecond_busy", {31'd0, busy_b}, 32'd0);
        end
        chk("l3_nosecond_instr", io_b, 32'h8D0A0004);

        // Reset mid-wait drops the pending load
        mem_b = 32'h0C100003;
        wr_b  = 1'b1;
        tick();
        wr_b  = 1'b0;
        tick();
        chk("mw_busy_before", {31'd0, busy_b}, 32'd1);
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        chk("mw_busy",  {31'd0, busy_b}, 32'd0);
        chk("mw_valid", {31'd0, vld_b},  32'd0);
        chk("mw_instr", io_b, 32'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("mw_late_valid", {31'd0, vld_b}, 32'd0);
        chk("mw_late_instr", io_b, 32'd0);
        mem_b = 32'h03E00008;
        wr_b  = 1'b1;
        tick();
        wr_b  = 1'b0;
        tick();
        tick();
        chk("mw_again_pre", {31'd0, vld_b}, 32'd0);
        tick();
        chk("mw_again_valid", {31'd0, vld_b}, 32'd1);
        chk("mw_again_instr", io_b, 32'h03E00008);
        chk("mw_again_fmt",   fmt_b, 32'd0);

        // Latency 0: capture on the request edge itself
        mem_c = 32'hAC0BFFF0;
        wr_c  = 1'b1;
        tick();
        wr_c  = 1'b0;
        chk("l0_valid", {31'd0, vld_c},  32'd1);
        chk("l0_busy",  {31'd0, busy_c}, 32'd0);
        chk("l0_op",    op_c, 32'h2B);
        chk("l0_rt",    rt_c, 32'd11);
        chk("l0_sext",  sx_c, 32'hFFFFFFF0);
        chk("l0_zext",  zx_c, 32'h0000FFF0);
        chk("l0_fmt",   fmt_c, 32'd1);
        mem_c = 32'h03E00008;
        wr_c  = 1'b1;
        tick();
        wr_c  = 1'b0;
        chk("l0_jr_valid", {31'd0, vld_c}, 32'd1);
        chk("l0_jr_rs",    rs_c, 32'd31);
        chk("l0_jr_funct", fn_c, 32'd8);
        chk("l0_jr_fmt",   fmt_c, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Busy and instr_valid must never overlap on any instance.
    always @(negedge clk) begin
        if ((busy_a && vld_a) || (busy_b && vld_b) || (busy_c && vld_c)) begin
            checks++;
            errors++;
            $error("FAIL busy_valid_overlap: observed a=%b%b b=%b%b c=%b%b expected no overlap",
                   busy_a, vld_a, busy_b, vld_b, busy_c, vld_c);
        end
    end

endmodule
